bus_sequencer: RTL and testbench
================================

Name: bus_sequencer

Overview:
- Hardwired control unit for the single-bus datapath. It steps a T-state machine through fetch and execute for every instruction.
- Each cycle it drives the 24-bit one-hot bus-source select into the bus encoder/mux, plus all register load strobes, ALU opcode and memory read/write.
- Sits between the IR, the memory handshake and the datapath. It is the only driver of bus-source selects.

Parameters:
- MEM_WAIT_MAX, 15: max cycles in a memory wait state before FAULT.
- ALU_OP_W, 5: width of alu_op.

Ports:
- clock  in  1  system clock
- clear_n  in  1  synchronous active-low reset
- run  in  1  level; 1 = fetch new instructions
- ir  in  32  IR contents: [31:27] opcode, [26:23] Ra, [22:19] Rb, [18:0] C
- mem_done  in  1  memory completes the current read/write this cycle
- bus_sel  out  24  one-hot source select: [15:0] R0-R15, 16 HI, 17 LO, 18 Z_HI, 19 Z_LO, 20 PC, 21 MDR, 22 InPort, 23 C_sign_extended
- reg_in  out  16  GPR load enables
- pc_in, inc_pc, mar_in, ir_in, y_in, z_in, hi_in, lo_in, mdr_in  out  1 each  load strobes
- mdr_from_mem  out  1  MDR input select: 1 = memory, 0 = bus
- mem_read, mem_write  out  1 each  memory request, held until mem_done
- alu_op  out  ALU_OP_W  ALU function
- halted, fault  out  1 each  sticky status
- tstate  out  4  current T-state, for debug

Behaviour:
- Reset: one clock, reset is synchronous and active-low (clear_n sampled on the rising clock edge).
  - clear_n=0 at an edge puts the FSM in IDLE, from any state including mid-wait.
  - All outputs are 0 while clear_n=0 and in the cycle after release.
- Every cycle: bus_sel has zero or one bit set. reg_in has at most one bit set. Only one of mem_read/mem_write is asserted.
- States: IDLE, T0..T8, HALT, FAULT. All transitions are registered. Outputs are decoded combinationally from state and ir.
- IDLE: leaves to T0 when run=1. Otherwise stays.
- Fetch:
  - T0: bus_sel[20], mar_in, inc_pc, z_in.
  - T1: bus_sel[18] (Z_HI holds PC+1), pc_in.
  - T2: mem_read=1 and mdr_from_mem=1 every cycle. Wait for mem_done; mdr_in is asserted only in the mem_done cycle.
  - T3: bus_sel[21], ir_in.
- Execute paths:
  - R-ALU (ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL): T4 Rb out, y_in; T5 Rc out (Rc=ir[18:15]), alu_op, z_in; T6 bus_sel[19], reg_in[Ra].
  - ADDI/ANDI/ORI: same path, except T5 drives bus_sel[23].
  - MUL/DIV: T4 Ra out, y_in; T5 Rb out, alu_op, z_in; T6 bus_sel[19], lo_in; T7 bus_sel[18], hi_in.
  - MFHI/MFLO: T4 bus_sel[16]/[17], reg_in[Ra].
  - LD and ST common part: T4 Rb out, y_in; T5 bus_sel[23], alu_op=ADD, z_in; T6 bus_sel[19], mar_in.
  - LD: T7 memory read wait as in T2; T8 bus_sel[21], reg_in[Ra].
  - ST: T7 Ra out, mdr_in, mdr_from_mem=0; T8 mem_write held until mem_done.
  - NOP: T3 goes to T0.
  - HALT: goes to HALT; halted=1 until reset.
  - Undefined opcode: FAULT.
- End of instruction: the last T-state goes to T0 if run=1, else IDLE. Deasserting run mid-instruction completes that instruction first.
- Memory wait:
  - Counter clears on entry to each wait state. It increments each cycle without mem_done.
  - Reaching MEM_WAIT_MAX goes to FAULT with mem_read/mem_write dropped.
  - mem_done in the same cycle the counter reaches MEM_WAIT_MAX counts as success.
  - mem_done outside a wait state is ignored.
- FAULT: all strobes 0, fault=1, exits only on reset.

Optional Feature:
- Macro SEQ_SINGLE_STEP_EN adds input port step (1 bit).
- With the macro: at an instruction boundary, T0 is entered only on a cycle where step=1 (and run=1); otherwise the FSM waits in IDLE. step held high runs continuously.
- Without the macro: no step port, and the boundary behaviour is exactly as above.

Decomposition:
- Shared package bus_ctrl_pkg:
  - Opcode constants (ADD=0..ROL=8, ADDI=9, ANDI=10, ORI=11, MUL=12, DIV=13, MFHI=14, MFLO=15, LD=16, ST=17, NOP=18, HALT=19).
  - ALU op constants.
  - Bus source index constants 0..23.
  - T-state enum.
- One sub-module: bus_seq_decode (combinational opcode/T-state to control-word decode). The FSM and wait counter stay in the top.

Test Plan:
- Reset then run=1, ir=ADD R3,R1,R2, mem_done on the 2nd T2 cycle:
  - T0 bus_sel=0x100000; T3 bus_sel=0x200000;
  - T4 bus_sel=0x000002; T5 bus_sel=0x000004 with alu_op=ADD; T6 reg_in=0x0008.
- ADDI R5,R4,-7: T5 bus_sel=0x800000; T6 reg_in=0x0020.
- LD R2,0x10(R1), mem_done withheld 15 cycles in T7: fault=1, mem_read=0, strobes 0.
- ST R6,4(R0), mem_done after 3 cycles:
  - T7 bus_sel=0x000040 with mdr_in=1, mdr_from_mem=0;
  - mem_write high for 3 cycles, then T0.
- MUL R3,R4 then MFHI R7: T6 lo_in, T7 hi_in; the next instruction drives T4 bus_sel=0x010000 with reg_in=0x0080.
- clear_n=0 during T2 wait: the next cycle is IDLE with all outputs 0. Throughout all scenarios, check bus_sel is 0 or one-hot every cycle.

Source files
------------

// File: rtl/bus_ctrl_pkg.sv
// Shared opcodes, ALU codes, bus-source indices, T-state codes and the
// control-word type used by the single-bus hardwired sequencer.
package bus_ctrl_pkg;

  localparam int ALU_W = 5;

  localparam logic [4:0] OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_AND  = 5'd2,
                         OP_OR   = 5'd3,  OP_SHR  = 5'd4,  OP_SHRA = 5'd5,
                         OP_SHL  = 5'd6,  OP_ROR  = 5'd7,  OP_ROL  = 5'd8,
                         OP_ADDI = 5'd9,  OP_ANDI = 5'd10, OP_ORI  = 5'd11,
                         OP_MUL  = 5'd12, OP_DIV  = 5'd13, OP_MFHI = 5'd14,
                         OP_MFLO = 5'd15, OP_LD   = 5'd16, OP_ST   = 5'd17,
                         OP_NOP  = 5'd18, OP_HALT = 5'd19;

  localparam logic [ALU_W-1:0] ALU_NOP = 5'd0,  ALU_ADD = 5'd1,  ALU_SUB  = 5'd2,
                               ALU_AND = 5'd3,  ALU_OR  = 5'd4,  ALU_SHR  = 5'd5,
                               ALU_SHRA = 5'd6, ALU_SHL = 5'd7,  ALU_ROR  = 5'd8,
                               ALU_ROL = 5'd9,  ALU_MUL = 5'd10, ALU_DIV  = 5'd11;

  // Bus sources 0..15 are the general registers R0..R15.
  localparam logic [4:0] SRC_HI = 5'd16, SRC_LO = 5'd17, SRC_Z_HI = 5'd18,
                         SRC_Z_LO = 5'd19, SRC_PC = 5'd20, SRC_MDR = 5'd21,
                         SRC_INPORT = 5'd22, SRC_C = 5'd23;

  localparam logic [3:0] ST_IDLE = 4'd0, ST_T0 = 4'd1, ST_T1 = 4'd2, ST_T2 = 4'd3,
                         ST_T3 = 4'd4, ST_T4 = 4'd5, ST_T5 = 4'd6, ST_T6 = 4'd7,
                         ST_T7 = 4'd8, ST_T8 = 4'd9, ST_HALT = 4'd10, ST_FAULT = 4'd11;

  typedef struct packed {
    logic [23:0]      bus_sel;
    logic [15:0]      reg_in;
    logic             pc_in;
    logic             inc_pc;
    logic             mar_in;
    logic             ir_in;
    logic             y_in;
    logic             z_in;
    logic             hi_in;
    logic             lo_in;
    logic             mdr_in;
    logic             mdr_from_mem;
    logic             mem_read;
    logic             mem_write;
    logic [ALU_W-1:0] alu_op;
    logic             halted;
    logic             fault;
  } ctrl_word_t;

  function automatic logic is_r_alu(input logic [4:0] op);
    return op <= OP_ROL;
  endfunction

  function automatic logic is_imm(input logic [4:0] op);
    return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
  endfunction

  function automatic logic is_muldiv(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  // Wait states are the two memory reads (fetch, LD) and the ST write.
  function automatic logic is_mem_wait(input logic [3:0] state, input logic [4:0] op);
    return (state == ST_T2) || (state == ST_T7 && op == OP_LD) ||
           (state == ST_T8 && op == OP_ST);
  endfunction

  function automatic logic [ALU_W-1:0] alu_for(input logic [4:0] op);
    case (op)
      OP_ADD, OP_ADDI, OP_LD, OP_ST: alu_for = ALU_ADD;
      OP_SUB:                        alu_for = ALU_SUB;
      OP_AND, OP_ANDI:               alu_for = ALU_AND;
      OP_OR, OP_ORI:                 alu_for = ALU_OR;
      OP_SHR:                        alu_for = ALU_SHR;
      OP_SHRA:                       alu_for = ALU_SHRA;
      OP_SHL:                        alu_for = ALU_SHL;
      OP_ROR:                        alu_for = ALU_ROR;
      OP_ROL:                        alu_for = ALU_ROL;
      OP_MUL:                        alu_for = ALU_MUL;
      OP_DIV:                        alu_for = ALU_DIV;
      default:                       alu_for = ALU_NOP;
    endcase
  endfunction

  function automatic logic [23:0] src_sel(input logic [4:0] idx);
    return 24'd1 << idx;
  endfunction

  function automatic logic [15:0] gpr_sel(input logic [3:0] r);
    return 16'd1 << r;
  endfunction

endpackage

// File: rtl/bus_seq_decode.sv
// Combinational decode of (T-state, IR opcode/fields) into the datapath control word.
module bus_seq_decode
  import bus_ctrl_pkg::*;
(
  input  logic [3:0]  state,
  input  logic [31:0] ir,
  input  logic        mem_done,
  output ctrl_word_t  ctrl
);

  logic [4:0] op;
  logic [3:0] ra, rb, rc;
  logic       ir_unused;

  assign op = ir[31:27];
  assign ra = ir[26:23];
  assign rb = ir[22:19];
  assign rc = ir[18:15];
  // The constant field only reaches the datapath through the C_sign_extended source.
  assign ir_unused = ^ir[14:0];

  always_comb begin
    ctrl = '0;
    case (state)
      ST_T0: begin
        ctrl.bus_sel = src_sel(SRC_PC);
        ctrl.mar_in  = 1'b1;
        ctrl.inc_pc  = 1'b1;
        ctrl.z_in    = 1'b1;
      end
      ST_T1: begin
        ctrl.bus_sel = src_sel(SRC_Z_HI);
        ctrl.pc_in   = 1'b1;
      end
      ST_T2: begin
        ctrl.mem_read     = 1'b1;
        ctrl.mdr_from_mem = 1'b1;
        ctrl.mdr_in       = mem_done;
      end
      ST_T3: begin
        ctrl.bus_sel = src_sel(SRC_MDR);
        ctrl.ir_in   = 1'b1;
      end
      ST_T4: begin
        if (is_muldiv(op)) begin
          ctrl.bus_sel = src_sel({1'b0, ra});
          ctrl.y_in    = 1'b1;
        end else if (op == OP_MFHI || op == OP_MFLO) begin
          ctrl.bus_sel = src_sel(op == OP_MFHI ? SRC_HI : SRC_LO);
          ctrl.reg_in  = gpr_sel(ra);
        end else if (is_r_alu(op) || is_imm(op) || op == OP_LD || op == OP_ST) begin
          ctrl.bus_sel = src_sel({1'b0, rb});
          ctrl.y_in    = 1'b1;
        end
      end
      ST_T5: begin
        if (is_r_alu(op) || is_muldiv(op) || is_imm(op) || op == OP_LD || op == OP_ST) begin
          ctrl.alu_op = alu_for(op);
          ctrl.z_in   = 1'b1;
          if (is_r_alu(op))
            ctrl.bus_sel = src_sel({1'b0, rc});
          else if (is_muldiv(op))
            ctrl.bus_sel = src_sel({1'b0, rb});
          else
            ctrl.bus_sel = src_sel(SRC_C);
        end
      end
      ST_T6: begin
        ctrl.bus_sel = src_sel(SRC_Z_LO);
        if (is_r_alu(op) || is_imm(op))
          ctrl.reg_in = gpr_sel(ra);
        else if (is_muldiv(op))
          ctrl.lo_in = 1'b1;
        else if (op == OP_LD || op == OP_ST)
          ctrl.mar_in = 1'b1;
        else
          ctrl.bus_sel = '0;
      end
      ST_T7: begin
        if (is_muldiv(op)) begin
          ctrl.bus_sel = src_sel(SRC_Z_HI);
          ctrl.hi_in   = 1'b1;
        end else if (op == OP_LD) begin
          ctrl.mem_read     = 1'b1;
          ctrl.mdr_from_mem = 1'b1;
          ctrl.mdr_in       = mem_done;
        end else if (op == OP_ST) begin
          ctrl.bus_sel = src_sel({1'b0, ra});
          ctrl.mdr_in  = 1'b1;
        end
      end
      ST_T8: begin
        if (op == OP_LD) begin
          ctrl.bus_sel = src_sel(SRC_MDR);
          ctrl.reg_in  = gpr_sel(ra);
        end else if (op == OP_ST) begin
          ctrl.mem_write = 1'b1;
        end
      end
      ST_HALT:  ctrl.halted = 1'b1;
      ST_FAULT: ctrl.fault  = 1'b1;
      default:  ctrl = '0;
    endcase
  end

endmodule

// File: rtl/bus_sequencer.sv
// Hardwired T-state control unit for the single-bus datapath (fetch + execute).
// Define SEQ_SINGLE_STEP_EN to add a 'step' input that gates each new instruction.
module bus_sequencer
  import bus_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15,
  parameter int ALU_OP_W     = 5
) (
  input  logic                clock,
  input  logic                clear_n,
  input  logic                run,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic                step,
`endif
  input  logic [31:0]         ir,
  input  logic                mem_done,
  output logic [23:0]         bus_sel,
  output logic [15:0]         reg_in,
  output logic                pc_in,
  output logic                inc_pc,
  output logic                mar_in,
  output logic                ir_in,
  output logic                y_in,
  output logic                z_in,
  output logic                hi_in,
  output logic                lo_in,
  output logic                mdr_in,
  output logic                mdr_from_mem,
  output logic                mem_read,
  output logic                mem_write,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                halted,
  output logic                fault,
  output logic [3:0]          tstate
);

  localparam int             CNT_W    = $clog2(MEM_WAIT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_WAIT_MAX - 1);

  logic [3:0]       state, state_nxt, end_state;
  logic [CNT_W-1:0] wait_cnt;
  logic [4:0]       op;
  logic             go, in_wait, timeout;
  ctrl_word_t       ctrl, ctrl_out;

  assign op = ir[31:27];

`ifdef SEQ_SINGLE_STEP_EN
  assign go = run && step;
`else
  assign go = run;
`endif

  // A wait that has used its whole budget without mem_done gives up this cycle.
  assign in_wait   = is_mem_wait(state, op);
  assign timeout   = in_wait && !mem_done && (wait_cnt == CNT_LAST);
  assign end_state = go ? ST_T0 : ST_IDLE;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (go) state_nxt = ST_T0;
      ST_T0:   state_nxt = ST_T1;
      ST_T1:   state_nxt = ST_T2;
      ST_T2:   if (mem_done) state_nxt = ST_T3;
               else if (timeout) state_nxt = ST_FAULT;
      ST_T3: begin
        if (op == OP_NOP)       state_nxt = end_state;
        else if (op == OP_HALT) state_nxt = ST_HALT;
        else if (op <= OP_ST)   state_nxt = ST_T4;
        else                    state_nxt = ST_FAULT;
      end
      ST_T4:   state_nxt = (op == OP_MFHI || op == OP_MFLO) ? end_state : ST_T5;
      ST_T5:   state_nxt = ST_T6;
      ST_T6:   state_nxt = (is_r_alu(op) || is_imm(op)) ? end_state : ST_T7;
      ST_T7: begin
        if (is_muldiv(op))    state_nxt = end_state;
        else if (op == OP_ST) state_nxt = ST_T8;
        else if (op == OP_LD) begin
          if (mem_done)     state_nxt = ST_T8;
          else if (timeout) state_nxt = ST_FAULT;
        end else            state_nxt = ST_FAULT;
      end
      ST_T8: begin
        if (op == OP_LD) state_nxt = end_state;
        else if (op == OP_ST) begin
          if (mem_done)     state_nxt = end_state;
          else if (timeout) state_nxt = ST_FAULT;
        end else            state_nxt = ST_FAULT;
      end
      ST_HALT:  state_nxt = ST_HALT;
      ST_FAULT: state_nxt = ST_FAULT;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // The wait counter only survives while the FSM stays in the same wait state.
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= (in_wait && state_nxt == state) ? wait_cnt + 1'b1 : '0;
    end
  end

  bus_seq_decode u_decode (
    .state    (state),
    .ir       (ir),
    .mem_done (mem_done),
    .ctrl     (ctrl)
  );

  // Reset forces every output low immediately, not just after the next edge.
  assign ctrl_out     = clear_n ? ctrl : '0;
  assign tstate       = clear_n ? state : ST_IDLE;
  assign bus_sel      = ctrl_out.bus_sel;
  assign reg_in       = ctrl_out.reg_in;
  assign pc_in        = ctrl_out.pc_in;
  assign inc_pc       = ctrl_out.inc_pc;
  assign mar_in       = ctrl_out.mar_in;
  assign ir_in        = ctrl_out.ir_in;
  assign y_in         = ctrl_out.y_in;
  assign z_in         = ctrl_out.z_in;
  assign hi_in        = ctrl_out.hi_in;
  assign lo_in        = ctrl_out.lo_in;
  assign mdr_in       = ctrl_out.mdr_in;
  assign mdr_from_mem = ctrl_out.mdr_from_mem;
  assign mem_read     = ctrl_out.mem_read;
  assign mem_write    = ctrl_out.mem_write;
  assign alu_op       = ALU_OP_W'(ctrl_out.alu_op);
  assign halted       = ctrl_out.halted;
  assign fault        = ctrl_out.fault;

endmodule

// File: tb/tb_bus_sequencer.sv
// Directed, table-driven bench for bus_sequencer: one vector per clock,
// checked on the falling edge against hand-computed control words.
module tb_bus_sequencer;

  localparam logic [13:0] PC_IN   = 14'h2000, INC_PC  = 14'h1000, MAR_IN = 14'h0800,
                          IR_IN   = 14'h0400, Y_IN    = 14'h0200, Z_IN   = 14'h0100,
                          HI_IN   = 14'h0080, LO_IN   = 14'h0040, MDR_IN = 14'h0020,
                          MDR_MEM = 14'h0010, MEM_RD  = 14'h0008, MEM_WR = 14'h0004,
                          HALTED  = 14'h0002, FAULTED = 14'h0001;

  localparam logic [4:0] A_ADD = 5'd1, A_MUL = 5'd10;

  localparam logic [31:0] I_ADD  = 32'h0189_0000, I_ADDI = 32'h4AA7_FFF9,
                          I_MUL  = 32'h61A0_0000, I_MFHI = 32'h7380_0000,
                          I_ST   = 32'h8B00_0004, I_NOP  = 32'h9000_0000,
                          I_LD   = 32'h8108_0010, I_HALT = 32'h9800_0000,
                          I_BAD  = 32'hA000_0000;

  typedef struct packed {
    logic        clear_n;
    logic        run;
    logic        mem_done;
    logic [31:0] ir;
    logic [23:0] bus;
    logic [15:0] regs;
    logic [13:0] strb;
    logic [4:0]  alu;
    logic [3:0]  ts;
  } vec_t;

  logic        clock;
  logic        clear_n, run, mem_done;
  logic [31:0] ir;
  logic [23:0] bus_sel;
  logic [15:0] reg_in;
  logic        pc_in, inc_pc, mar_in, ir_in, y_in, z_in, hi_in, lo_in;
  logic        mdr_in, mdr_from_mem, mem_read, mem_write, halted, fault;
  logic [4:0]  alu_op;
  logic [3:0]  tstate;
  logic [13:0] strb_act;
`ifdef SEQ_SINGLE_STEP_EN
  logic        step;
  initial step = 1'b1;
`endif

  int   errors = 0;
  int   checks = 0;
  vec_t tbl[$];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  bus_sequencer #(.MEM_WAIT_MAX(15), .ALU_OP_W(5)) dut (
    .clock        (clock),
    .clear_n      (clear_n),
    .run          (run),
`ifdef SEQ_SINGLE_STEP_EN
    .step         (step),
`endif
    .ir           (ir),
    .mem_done     (mem_done),
    .bus_sel      (bus_sel),
    .reg_in       (reg_in),
    .pc_in        (pc_in),
    .inc_pc       (inc_pc),
    .mar_in       (mar_in),
    .ir_in        (ir_in),
    .y_in         (y_in),
    .z_in         (z_in),
    .hi_in        (hi_in),
    .lo_in        (lo_in),
    .mdr_in       (mdr_in),
    .mdr_from_mem (mdr_from_mem),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .alu_op       (alu_op),
    .halted       (halted),
    .fault        (fault),
    .tstate       (tstate)
  );

  assign strb_act = {pc_in, inc_pc, mar_in, ir_in, y_in, z_in, hi_in, lo_in,
                     mdr_in, mdr_from_mem, mem_read, mem_write, halted, fault};

  function automatic vec_t mk(input logic cn, input logic r, input logic md,
                              input logic [31:0] i, input logic [23:0] b,
                              input logic [15:0] g, input logic [13:0] s,
                              input logic [4:0] a, input logic [3:0] t);
    vec_t v;
    v.clear_n = cn; v.run = r; v.mem_done = md; v.ir = i;
    v.bus = b; v.regs = g; v.strb = s; v.alu = a; v.ts = t;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    clear_n  = v.clear_n;
    run      = v.run;
    mem_done = v.mem_done;
    ir       = v.ir;
  endtask

  task automatic checkOutput(input vec_t v, input string tag);
    checks++;
    if (bus_sel !== v.bus) begin
      errors++;
      $display("[TB] FAIL %s bus_sel got=%h want=%h", tag, bus_sel, v.bus);
    end
    checks++;
    if (reg_in !== v.regs) begin
      errors++;
      $display("[TB] FAIL %s reg_in got=%h want=%h", tag, reg_in, v.regs);
    end
    checks++;
    if (strb_act !== v.strb) begin
      errors++;
      $display("[TB] FAIL %s strobes got=%b want=%b", tag, strb_act, v.strb);
    end
    checks++;
    if (alu_op !== v.alu) begin
      errors++;
      $display("[TB] FAIL %s alu_op got=%0d want=%0d", tag, alu_op, v.alu);
    end
    checks++;
    if (tstate !== v.ts) begin
      errors++;
      $display("[TB] FAIL %s tstate got=%0d want=%0d", tag, tstate, v.ts);
    end
    checks++;
    if (!$onehot0(bus_sel) || !$onehot0(reg_in) || (mem_read && mem_write)) begin
      errors++;
      $display("[TB] FAIL %s exclusivity bus_sel=%h reg_in=%h rd=%b wr=%b want one-hot-or-zero",
               tag, bus_sel, reg_in, mem_read, mem_write);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    applyStimulus(v);
    @(negedge clock);
    checkOutput(v, tag);
    @(posedge clock);
    #1;
  endtask

  task automatic run_table(input string name);
    foreach (tbl[k]) run_vec(tbl[k], $sformatf("%s.%0d", name, k));
    tbl.delete();
  endtask

  // Reset cycle, then release with run=1 so the next edge enters T0.
  task automatic add_reset(input logic [31:0] i);
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, i, 24'h0, 16'h0, 14'h0, 5'd0, 4'd0));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, i, 24'h0, 16'h0, 14'h0, 5'd0, 4'd0));
  endtask

  task automatic add_fetch(input logic [31:0] i, input int waits, input logic r);
    tbl.push_back(mk(1'b1, r, 1'b0, i, 24'h100000, 16'h0, MAR_IN | INC_PC | Z_IN, 5'd0, 4'd1));
    tbl.push_back(mk(1'b1, r, 1'b0, i, 24'h040000, 16'h0, PC_IN, 5'd0, 4'd2));
    for (int k = 0; k < waits; k++)
      tbl.push_back(mk(1'b1, r, 1'b0, i, 24'h0, 16'h0, MDR_MEM | MEM_RD, 5'd0, 4'd3));
    tbl.push_back(mk(1'b1, r, 1'b1, i, 24'h0, 16'h0, MDR_MEM | MEM_RD | MDR_IN, 5'd0, 4'd3));
    tbl.push_back(mk(1'b1, r, 1'b0, i, 24'h200000, 16'h0, IR_IN, 5'd0, 4'd4));
  endtask

  task automatic add_ld_address(input logic [31:0] i);
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, i, 24'h000002, 16'h0, Y_IN, 5'd0, 4'd5));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, i, 24'h800000, 16'h0, Z_IN, A_ADD, 4'd6));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, i, 24'h080000, 16'h0, MAR_IN, 5'd0, 4'd7));
  endtask

  initial begin
    clear_n = 1'b0; run = 1'b0; mem_done = 1'b0; ir = 32'h0;
    @(posedge clock);
    #1;

    // Main program: ADD, ADDI, MUL, MFHI, ST, then NOP with run dropped.
    add_reset(I_ADD);
    add_fetch(I_ADD, 1, 1'b1);
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, I_ADD, 24'h000002, 16'h0, Y_IN, 5'd0, 4'd5));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, I_ADD, 24'h000004, 16'h0, Z_IN, A_ADD, 4'd6));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, I_ADD, 24'h080000, 16'h0008, 14'h0, 5'd0, 4'd7));
    add_fetch(I_ADDI, 0, 1'b1);
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, I_ADDI, 24'h000010, 16'h0, Y_IN, 5'd0, 4'd5));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, I_ADDI, 24'h800000, 16'h0, Z_IN, A_ADD, 4'd6));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, I_ADDI, 24'h080000, 16'h0020, 14'h0, 5'd0, 4'd7));
    add_fetch(I_MUL, 0, 1'b1);
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, I_MUL, 24'h000008, 16'h0, Y_IN, 5'd0, 4'd5));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, I_MUL, 24'h000010, 16'h0, Z_IN, A_MUL, 4'd6));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, I_MUL, 24'h080000, 16'h0, LO_IN, 5'd0, 4'd7));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, I_MUL, 24'h040000, 16'h0, HI_IN, 5'd0, 4'd8));
    add_fetch(I_MFHI, 0, 1'b1);
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, I_MFHI, 24'h010000, 16'h0080, 14'h0, 5'd0, 4'd5));
    add_fetch(I_ST, 0, 1'b1);
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, I_ST, 24'h000001, 16'h0, Y_IN, 5'd0, 4'd5));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, I_ST, 24'h800000, 16'h0, Z_IN, A_ADD, 4'd6));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, I_ST, 24'h080000, 16'h0, MAR_IN, 5'd0, 4'd7));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, I_ST, 24'h000040, 16'h0, MDR_IN, 5'd0, 4'd8));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, I_ST, 24'h0, 16'h0, MEM_WR, 5'd0, 4'd9));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, I_ST, 24'h0, 16'h0, MEM_WR, 5'd0, 4'd9));
    tbl.push_back(mk(1'b1, 1'b1, 1'b1, I_ST, 24'h0, 16'h0, MEM_WR, 5'd0, 4'd9));
    add_fetch(I_NOP, 0, 1'b0);
    tbl.push_back(mk(1'b1, 1'b0, 1'b1, I_NOP, 24'h0, 16'h0, 14'h0, 5'd0, 4'd0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, I_NOP, 24'h0, 16'h0, 14'h0, 5'd0, 4'd0));
    run_table("main");

    // LD with mem_done withheld for the whole wait budget ends in FAULT.
    add_reset(I_LD);
    add_fetch(I_LD, 0, 1'b1);
    add_ld_address(I_LD);
    for (int k = 0; k < 15; k++)
      tbl.push_back(mk(1'b1, 1'b1, 1'b0, I_LD, 24'h0, 16'h0, MDR_MEM | MEM_RD, 5'd0, 4'd8));
    tbl.push_back(mk(1'b1, 1'b1, 1'b1, I_LD, 24'h0, 16'h0, FAULTED, 5'd0, 4'd11));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, I_LD, 24'h0, 16'h0, FAULTED, 5'd0, 4'd11));
    run_table("ld_timeout");

    // LD whose mem_done lands on the last allowed wait cycle still completes.
    add_reset(I_LD);
    add_fetch(I_LD, 0, 1'b1);
    add_ld_address(I_LD);
    for (int k = 0; k < 14; k++)
      tbl.push_back(mk(1'b1, 1'b1, 1'b0, I_LD, 24'h0, 16'h0, MDR_MEM | MEM_RD, 5'd0, 4'd8));
    tbl.push_back(mk(1'b1, 1'b1, 1'b1, I_LD, 24'h0, 16'h0, MDR_MEM | MEM_RD | MDR_IN, 5'd0, 4'd8));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, I_LD, 24'h200000, 16'h0004, 14'h0, 5'd0, 4'd9));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, I_LD, 24'h0, 16'h0, 14'h0, 5'd0, 4'd0));
    run_table("ld_edge");

    // Reset asserted mid fetch wait: outputs drop at once, then IDLE.
    add_reset(I_ADD);
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, I_ADD, 24'h100000, 16'h0, MAR_IN | INC_PC | Z_IN, 5'd0, 4'd1));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, I_ADD, 24'h040000, 16'h0, PC_IN, 5'd0, 4'd2));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, I_ADD, 24'h0, 16'h0, MDR_MEM | MEM_RD, 5'd0, 4'd3));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, I_ADD, 24'h0, 16'h0, MDR_MEM | MEM_RD, 5'd0, 4'd3));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, I_ADD, 24'h0, 16'h0, 14'h0, 5'd0, 4'd0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b1, I_ADD, 24'h0, 16'h0, 14'h0, 5'd0, 4'd0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, I_ADD, 24'h0, 16'h0, 14'h0, 5'd0, 4'd0));
    run_table("reset_wait");

    // HALT is sticky until reset; an undefined opcode faults.
    add_reset(I_HALT);
    add_fetch(I_HALT, 0, 1'b1);
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, I_HALT, 24'h0, 16'h0, HALTED, 5'd0, 4'd10));
    tbl.push_back(mk(1'b1, 1'b1, 1'b1, I_HALT, 24'h0, 16'h0, HALTED, 5'd0, 4'd10));
    add_reset(I_BAD);
    add_fetch(I_BAD, 0, 1'b1);
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, I_BAD, 24'h0, 16'h0, FAULTED, 5'd0, 4'd11));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, I_BAD, 24'h0, 16'h0, 14'h0, 5'd0, 4'd0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, I_BAD, 24'h0, 16'h0, 14'h0, 5'd0, 4'd0));
    run_table("halt_fault");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
